// File: rtl/control_sequencer.sv
// Multi-cycle ALU control sequencer: one opcode per handshake, 1-3 EXEC steps, each emitting an ALUOp code plus datapath strobes.
// Latency: accept -> EXEC step(s) -> DONE -> IDLE, so at best one accept every 3 cycles. Backpressure: instr_ready only in IDLE; alu_busy stalls a step until the watchdog forces an advance.
// Optional ILLEGAL_TRAP_EN: illegal opcodes pulse `illegal`; otherwise they run silently as NOP.
module control_sequencer #(
    parameter int OPW       = 5,
    parameter int AOPW      = 6,
    parameter int STALL_MAX = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [OPW-1:0]  opcode,
    input  logic            alu_busy,
    output logic [AOPW-1:0] alu_op,
    output logic            alu_op_valid,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            flag_write,
    output logic            pc_load,
    output logic            done,
    output logic            timeout,
    output logic            illegal
);

    localparam int SCW = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_MAX);
    localparam logic [5:0] NOP_CODE = 6'b010101;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [OPW-1:0] op_q, op_nxt;
    logic [1:0]     step_q, step_nxt;
    logic [SCW-1:0] stall_q, stall_nxt;

    logic [5:0] code;
    logic [1:0] last_step;
    logic       s_mr, s_mw, s_rw, s_fw, s_pc;
    logic       wd_fire;

    // Opcode/step decode; anything outside the table falls through as a one-step NOP.
    always_comb begin
        code      = NOP_CODE;
        last_step = 2'd0;
        s_mr      = 1'b0;
        s_mw      = 1'b0;
        s_rw      = 1'b0;
        s_fw      = 1'b0;
        s_pc      = 1'b0;
        case (int'(op_q))
            0: begin
                last_step = 2'd2;
                case (step_q)
                    2'd0:    code = 6'b000000;
                    2'd1:    begin code = 6'b000001; s_mr = 1'b1; end
                    default: begin code = 6'b000010; s_rw = 1'b1; end
                endcase
            end
            1: begin
                last_step = 2'd1;
                if (step_q == 2'd0) code = 6'b000011;
                else begin code = 6'b000100; s_mw = 1'b1; end
            end
            2:  begin code = 6'b000101; s_rw = 1'b1; end
            3:  begin code = 6'b000110; s_rw = 1'b1; end
            4:  begin code = 6'b000111; s_rw = 1'b1; end
            5:  begin code = 6'b001000; s_rw = 1'b1; end
            6:  begin code = 6'b001001; s_rw = 1'b1; end
            7:  begin code = 6'b001010; s_rw = 1'b1; end
            8:  begin code = 6'b001011; s_rw = 1'b1; end
            9:  begin code = 6'b001100; s_rw = 1'b1; end
            10: begin code = 6'b001101; s_rw = 1'b1; end
            11: begin code = 6'b001110; s_fw = 1'b1; end
            12: begin code = 6'b001111; s_rw = 1'b1; end
            13: begin code = 6'b010000; s_pc = 1'b1; end
            14: begin code = 6'b010001; s_pc = 1'b1; end
            15: begin code = 6'b010010; s_pc = 1'b1; end
            16: begin code = 6'b010011; s_rw = 1'b1; s_pc = 1'b1; end
            17: begin code = 6'b010100; s_pc = 1'b1; end
            default: code = NOP_CODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= '0;
            step_q  <= 2'd0;
            stall_q <= '0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            step_q  <= step_nxt;
            stall_q <= stall_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        op_nxt       = op_q;
        step_nxt     = step_q;
        stall_nxt    = stall_q;
        instr_ready  = 1'b0;
        alu_op       = AOPW'(NOP_CODE);
        alu_op_valid = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        flag_write   = 1'b0;
        pc_load      = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        wd_fire      = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_nxt    = opcode;
                    step_nxt  = 2'd0;
                    stall_nxt = '0;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op       = AOPW'(code);
                alu_op_valid = 1'b1;
                mem_read     = s_mr;
                mem_write    = s_mw;
                reg_write    = s_rw;
                flag_write   = s_fw;
                pc_load      = s_pc;
                // Watchdog only fires once the count has saturated and busy is still held.
                wd_fire      = alu_busy && (stall_q == STALL_LIM);
                timeout      = wd_fire;
                if (!alu_busy || wd_fire) begin
                    stall_nxt = '0;
                    if (step_q == last_step) state_nxt = S_DONE;
                    else                     step_nxt  = step_q + 2'd1;
                end else if (stall_q != STALL_LIM) begin
                    stall_nxt = stall_q + SCW'(1);
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    // stall_q is zero only on the first cycle of a step, so this is a single pulse.
    assign illegal = (state == S_EXEC) && (int'(op_q) > 18) && (stall_q == '0);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer; instance 0 uses STALL_MAX=255, instance 1 STALL_MAX=3.
module tb_control_sequencer;

    localparam int SM [2] = '{255, 3};
    localparam logic [15:0] IDLE_V = {1'b1, 6'h15, 1'b0, 5'b0, 3'b0};
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, instr_valid, alu_busy;
    logic [4:0] opcode;

    logic       instr_ready [2];
    logic [5:0] alu_op      [2];
    logic       alu_op_valid[2];
    logic       mem_read    [2];
    logic       mem_write   [2];
    logic       reg_write   [2];
    logic       flag_write  [2];
    logic       pc_load     [2];
    logic       done        [2];
    logic       timeout     [2];
    logic       illegal     [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_sequencer #(.OPW(5), .AOPW(6), .STALL_MAX(SM[g])) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .instr_valid  (instr_valid),
            .instr_ready  (instr_ready[g]),
            .opcode       (opcode),
            .alu_busy     (alu_busy),
            .alu_op       (alu_op[g]),
            .alu_op_valid (alu_op_valid[g]),
            .mem_read     (mem_read[g]),
            .mem_write    (mem_write[g]),
            .reg_write    (reg_write[g]),
            .flag_write   (flag_write[g]),
            .pc_load      (pc_load[g]),
            .done         (done[g]),
            .timeout      (timeout[g]),
            .illegal      (illegal[g])
        );
    end

    function automatic logic [15:0] obs(input int d);
        return {instr_ready[d], alu_op[d], alu_op_valid[d], mem_read[d], mem_write[d],
                reg_write[d], flag_write[d], pc_load[d], done[d], timeout[d], illegal[d]};
    endfunction

    function automatic logic [15:0] pack(input logic rdy, input logic [5:0] code, input logic vld,
                                         input logic [4:0] str, input logic dn, input logic to,
                                         input logic ill);
        return {rdy, code, vld, str, dn, to, ill};
    endfunction

    // Reference model straight from the opcode table.
    function automatic int n_steps(input int op);
        return (op == 0) ? 3 : (op == 1) ? 2 : 1;
    endfunction

    function automatic logic [5:0] exp_code(input int op, input int s);
        if (op == 0)  return 6'(s);
        if (op == 1)  return 6'(3 + s);
        if (op <= 18) return 6'(op + 3);
        return 6'h15;
    endfunction

    // {mem_read, mem_write, reg_write, flag_write, pc_load}
    function automatic logic [4:0] exp_str(input int op, input int s);
        logic mr, mw, rw, fw, pc;
        mr = (op == 0 && s == 1);
        mw = (op == 1 && s == 1);
        rw = (op == 0 && s == 2) || (op >= 2 && op <= 12 && op != 11) || (op == 16);
        fw = (op == 11);
        pc = (op >= 13 && op <= 17);
        return {mr, mw, rw, fw, pc};
    endfunction

    // Issues one opcode to instance d (starting in IDLE, #1 after a rising edge); each step sees
    // a busy run of b cycles drawn from [bmin,bmax], and every cycle is compared to the model.
    task automatic run_instr(input int op, input int d, input int bmin, input int bmax, input string tag);
        logic [15:0] e, o;
        int b, nc;
        instr_valid = 1'b1;
        opcode      = op[4:0];
        alu_busy    = 1'b0;
        @(negedge clk);
        o = obs(d); n_chk++;
        if (o !== IDLE_V) begin
            n_fail++; $display("FAIL %s accept op=%0d: got %h expected %h", tag, op, o, IDLE_V);
        end
        @(posedge clk); #1;
        for (int s = 0; s < n_steps(op); s++) begin
            b  = $urandom_range(bmax, bmin);
            nc = ((b < SM[d]) ? b : SM[d]) + 1;
            for (int c = 0; c < nc; c++) begin
                alu_busy    = (c < b);
                instr_valid = 1'($urandom_range(0, 1));
                opcode      = 5'($urandom);
                @(negedge clk);
                e = pack(1'b0, exp_code(op, s), 1'b1, exp_str(op, s), 1'b0,
                         (b > SM[d]) && (c == nc - 1), TRAP && (op > 18) && (c == 0));
                o = obs(d); n_chk++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL %s exec op=%0d step=%0d cyc=%0d busy_run=%0d: got %h expected %h",
                             tag, op, s, c, b, o, e);
                end
                @(posedge clk); #1;
            end
        end
        alu_busy = 1'($urandom_range(0, 1));
        @(negedge clk);
        e = pack(1'b0, 6'h15, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0);
        o = obs(d); n_chk++;
        if (o !== e) begin
            n_fail++; $display("FAIL %s done op=%0d: got %h expected %h", tag, op, o, e);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        alu_busy    = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b0; alu_busy = 1'b0; opcode = 5'd0;
        #1;
        n_chk++;
        if (obs(0) !== IDLE_V) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", obs(0), IDLE_V);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (obs(d) !== IDLE_V) begin
                n_fail++; $display("FAIL reset_release dut%0d: got %h expected %h", d, obs(d), IDLE_V);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_step;
        run_instr(3, 0, 0, 0, "add");
    endtask

    task automatic test_lw;
        run_instr(0, 0, 0, 0, "lw");
    endtask

    task automatic test_stall;
        run_instr(5, 0, 4, 4, "mul_stall");
    endtask

    task automatic test_illegal;
        run_instr(31, 0, 0, 0, "illegal_1f");
        for (int i = 0; i < 6; i++) run_instr($urandom_range(31, 19), 0, 0, 2, "illegal_rand");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 40; i++) run_instr($urandom_range(31, 0), 0, 0, 3, "b2b");
    endtask

    task automatic test_reset_mid;
        logic [15:0] e;
        instr_valid = 1'b1; opcode = 5'd1; alu_busy = 1'b0;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        e = pack(1'b0, 6'h04, 1'b1, 5'b01000, 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (obs(0) !== e) begin
            n_fail++; $display("FAIL sw_step1: got %h expected %h", obs(0), e);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs(0) !== IDLE_V) begin
            n_fail++; $display("FAIL rst_async: got %h expected %h", obs(0), IDLE_V);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs(0) !== IDLE_V) begin
                n_fail++; $display("FAIL rst_held: got %h expected %h", obs(0), IDLE_V);
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs(0) !== IDLE_V) begin
            n_fail++; $display("FAIL rst_after_release: got %h expected %h", obs(0), IDLE_V);
        end
        @(posedge clk); #1;
        run_instr(1, 0, 0, 1, "sw_after_rst");
    endtask

    task automatic test_watchdog;
        run_instr(6, 1, 10, 10, "div_wd");
        for (int i = 0; i < 20; i++) run_instr($urandom_range(31, 0), 1, 0, 6, "wd_rand");
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_lw();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_watchdog();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
